// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch unit, its program ROM and the instruction consumer.
// The master side is the fetch unit itself; the slave side is its environment
// (ROM plus the execute stage that takes instructions).
interface instruction_fetch_if;
  logic [7:0] romAddress;
  logic [7:0] romData;
  logic       halt;
  logic       instrValid;
  logic       instrAccept;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instrAddress;
  logic       jumpEnable;
  logic [7:0] jumpTarget;

  modport master (
    output romAddress,
    output instrValid,
    output opcode,
    output operand,
    output instrAddress,
    input  romData,
    input  halt,
    input  instrAccept,
    input  jumpEnable,
    input  jumpTarget
  );

  modport slave (
    input  romAddress,
    input  instrValid,
    input  opcode,
    input  operand,
    input  instrAddress,
    output romData,
    output halt,
    output instrAccept,
    output jumpEnable,
    output jumpTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit for an 8-bit core with a registered program ROM.
// Fetches one opcode byte and, for two-byte opcodes, one operand byte, then
// holds the complete instruction until the consumer accepts it. An accept may
// redirect the program counter to a jump target.
module instruction_fetch (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    LATCH_OP  = 2'd1,
    LATCH_ARG = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] opcode_q;
  logic [7:0] operand_q;
  logic [7:0] instr_addr_q;
  logic       valid_q;
  logic       two_byte;

  // Opcodes 0x01-0x0A and 0x10-0x17 carry an operand byte; everything else stands alone.
  always_comb begin
    two_byte = 1'b0;
    if ((bus.romData >= 8'h01) && (bus.romData <= 8'h0A))
      two_byte = 1'b1;
    else if ((bus.romData >= 8'h10) && (bus.romData <= 8'h17))
      two_byte = 1'b1;
  end

  // Fetch sequencer: the ROM answers one cycle after the address, so each byte
  // is captured in the state after the PC pointed at it. PC wraps modulo 256.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= 8'h00;
      opcode_q     <= 8'h00;
      operand_q    <= 8'h00;
      instr_addr_q <= 8'h00;
      valid_q      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!bus.halt) begin
            pc           <= pc + 8'd1;
            instr_addr_q <= pc;
            state        <= LATCH_OP;
          end
        end
        LATCH_OP: begin
          opcode_q <= bus.romData;
          if (two_byte) begin
            pc    <= pc + 8'd1;
            state <= LATCH_ARG;
          end else begin
            operand_q <= 8'h00;
            valid_q   <= 1'b1;
            state     <= PRESENT;
          end
        end
        LATCH_ARG: begin
          operand_q <= bus.romData;
          valid_q   <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (bus.instrAccept) begin
            if (bus.jumpEnable)
              pc <= bus.jumpTarget;
            valid_q <= 1'b0;
            state   <= FETCH;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

  assign bus.romAddress   = pc;
  assign bus.instrValid   = valid_q;
  assign bus.opcode       = opcode_q;
  assign bus.operand      = operand_q;
  assign bus.instrAddress = instr_addr_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port romAddress, output, 8 bits: program-ROM read address; equals the internal PC register at all times.
REQ-004 SHALL have port romData, input, 8 bits: program-ROM registered output, valid the cycle after romAddress is presented.
REQ-005 SHALL have port halt, input, 1 bit: stalls the start of a new fetch while high.
REQ-006 SHALL have port instrValid, output, 1 bit: a complete instruction is held on opcode/operand/instrAddress.
REQ-007 SHALL have port instrAccept, input, 1 bit: the consumer takes the held instruction this cycle.
REQ-008 SHALL have port opcode, output, 8 bits: fetched opcode byte.
REQ-009 SHALL have port operand, output, 8 bits: fetched operand byte, or 0x00 for single-byte instructions.
REQ-010 SHALL have port instrAddress, output, 8 bits: ROM address of the held opcode.
REQ-011 SHALL have port jumpEnable, input, 1 bit: redirect the PC on accept.
REQ-012 SHALL have port jumpTarget, input, 8 bits: new PC value when jumpEnable is applied.

Function
REQ-013 SHALL implement a four-state FSM: FETCH, LATCH_OP, LATCH_ARG, PRESENT.
REQ-014 In FETCH with halt=0: pc <= pc+1, instrAddress <= pc, next state LATCH_OP; with halt=1: hold all state.
REQ-015 In LATCH_OP: opcode <= romData; if the opcode is two-byte, pc <= pc+1 and go to LATCH_ARG; otherwise operand <= 0x00 and go to PRESENT.
REQ-016 Two-byte opcodes SHALL be exactly 0x01–0x0A and 0x10–0x17; all other values, including 0x00 and 0xFF, are single-byte.
REQ-017 In LATCH_ARG: operand <= romData, next state PRESENT.
REQ-018 instrValid SHALL be 1 only in PRESENT; opcode, operand and instrAddress SHALL remain stable while instrValid=1.
REQ-019 In PRESENT with instrAccept=0: hold. With instrAccept=1: next state FETCH; if jumpEnable=1, pc <= jumpTarget.
REQ-020 jumpEnable SHALL be ignored unless instrValid=1 and instrAccept=1 in the same cycle.
REQ-021 halt SHALL be sampled only in FETCH; an instruction already in progress SHALL complete to PRESENT.
REQ-022 Latency from entering FETCH to instrValid=1 SHALL be 2 cycles for single-byte and 3 cycles for two-byte instructions.
REQ-023 Back-to-back throughput SHALL be one instruction per 3 cycles (single-byte) or 4 cycles (two-byte) with instrAccept held high.
REQ-024 PC arithmetic SHALL be 8-bit modulo: 0xFF+1 = 0x00.
REQ-025 A two-byte opcode at 0xFF SHALL take its operand from 0x00.
REQ-026 romData SHALL be ignored in FETCH and PRESENT.

Reset
REQ-027 On reset=1 at a clock edge: pc=0x00, state=FETCH, opcode=0x00, operand=0x00, instrAddress=0x00, instrValid=0.
REQ-028 Reset SHALL override all other inputs in any state, including mid-instruction and during halt.
REQ-029 The first post-reset cycle SHALL present romAddress=0x00.

Verification
REQ-030 ROM {0:0x01, 1:0xAA, 2:0x18, 3:0x0B}, instrAccept=1, release reset -> instrValid cycle 3: opcode 0x01, operand 0xAA, instrAddress 0x00; then 0x18/0x00 @0x02; then 0x0B/0x00 @0x03.
REQ-031 Hold instrAccept=0 for 5 cycles after first instrValid -> outputs and romAddress frozen; single accept -> next fetch begins at romAddress=0x02.
REQ-032 Accept with jumpEnable=1, jumpTarget=0x40 -> next FETCH drives romAddress=0x40, instrAddress=0x40; jumpEnable with instrAccept=0 -> no effect.
REQ-033 PC at 0xFF holding 0x02 and ROM[0x00]=0x0F -> opcode 0x02, operand 0x0F, instrAddress 0xFF; next romAddress=0x01.
REQ-034 halt=1 in FETCH for 4 cycles -> romAddress unchanged, instrValid=0; halt raised during LATCH_ARG -> instruction still reaches PRESENT.
REQ-035 Assert reset during LATCH_ARG -> next cycle state FETCH, romAddress=0x00, instrValid=0, opcode=0x00, operand=0x00.
